// File: rtl/menu_key_event_ctrl.sv
// ---------------------------------------------------------------------------
// menu_key_event_ctrl
//   Front-end for the menu push-buttons. Each key is synchronised, debounced
//   and turned into press / auto-repeat events. Events from all keys are
//   arbitrated into one FIFO that the CPU drains over Avalon-MM, and irq is
//   raised while events are waiting.
//
// Ports
//   clk, reset_n   system clock, asynchronous active-low reset
//   key_in         raw buttons, active-low, asynchronous to clk
//   address        Avalon word address: 0 STATUS, 1 EVENT, 2 CTRL, 3 CLEAR
//   read, write    Avalon strobes
//   writedata      Avalon write data
//   readdata       Avalon read data, registered (valid the cycle after read)
//   irq            level interrupt: irq_en & FIFO non-empty, registered
// ---------------------------------------------------------------------------

// Per-key channel: synchroniser, debouncer and press/repeat FSM.
// pend/pend_rep hold one outstanding event; a new event arriving while one is
// still pending merges into it (the later kind wins).
module menu_key_chan #(
  parameter int CW            = 26,
  parameter int DEBOUNCE_CYC  = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  input  logic repeat_en,
  input  logic grant,
  output logic deb_level,
  output logic pend,
  output logic pend_rep
);
  typedef enum logic [1:0] {RELEASED, HELD_DELAY, HELD_REPEAT} state_t;

  logic          s1, s2;
  logic          raw_pressed;
  logic [CW-1:0] dcnt;
  logic [CW-1:0] timer;
  state_t        state;

  assign raw_pressed = ~s2;

  // Counter only runs while the synchronised level disagrees with the
  // accepted one, so any glitch shorter than DEBOUNCE_CYC restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1        <= 1'b1;
      s2        <= 1'b1;
      dcnt      <= '0;
      deb_level <= 1'b0;
    end else begin
      s1 <= key_n;
      s2 <= s1;
      if (raw_pressed == deb_level) begin
        dcnt <= '0;
      end else if (dcnt >= CW'(DEBOUNCE_CYC - 1)) begin
        deb_level <= ~deb_level;
        dcnt      <= '0;
      end else begin
        dcnt <= dcnt + CW'(1);
      end
    end
  end

  // Grant clears pend first; an event raised in the same cycle re-sets it so
  // it is not lost behind the one being pushed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RELEASED;
      timer    <= '0;
      pend     <= 1'b0;
      pend_rep <= 1'b0;
    end else begin
      if (grant) pend <= 1'b0;
      case (state)
        RELEASED: begin
          if (deb_level) begin
            state    <= HELD_DELAY;
            timer    <= '0;
            pend     <= 1'b1;
            pend_rep <= 1'b0;
          end
        end
        HELD_DELAY: begin
          if (!deb_level) begin
            state <= RELEASED;
          end else if (repeat_en && timer >= CW'(REPEAT_DELAY - 1)) begin
            // >= so that enabling repeat after the delay expired fires at once
            state    <= HELD_REPEAT;
            timer    <= '0;
            pend     <= 1'b1;
            pend_rep <= 1'b1;
          end else if (timer != '1) begin
            timer <= timer + CW'(1);
          end
        end
        HELD_REPEAT: begin
          if (!deb_level) begin
            state <= RELEASED;
          end else if (timer >= CW'(REPEAT_PERIOD - 1)) begin
            timer    <= '0;
            pend     <= 1'b1;
            pend_rep <= 1'b1;
          end else if (timer != '1) begin
            timer <= timer + CW'(1);
          end
        end
        default: state <= RELEASED;
      endcase
    end
  end
endmodule

module menu_key_event_ctrl #(
  parameter int NUM_KEYS      = 4,
  parameter int DEBOUNCE_CYC  = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_in,
  input  logic [1:0]          address,
  input  logic                read,
  input  logic                write,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic                irq
);
  localparam int MAXA = (DEBOUNCE_CYC > REPEAT_DELAY) ? DEBOUNCE_CYC : REPEAT_DELAY;
  localparam int MAXP = (MAXA > REPEAT_PERIOD) ? MAXA : REPEAT_PERIOD;
  localparam int CW   = $clog2(MAXP) + 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int NW   = AW + 1;

  logic [NUM_KEYS-1:0] deb_level, pend, pend_rep, grant;
  logic [1:0]          ctrl;      // [0] irq_en, [1] repeat_en

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    menu_key_chan #(
      .CW(CW), .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_chan (
      .clk(clk), .reset_n(reset_n), .key_n(key_in[k]),
      .repeat_en(ctrl[1]), .grant(grant[k]),
      .deb_level(deb_level[k]), .pend(pend[k]), .pend_rep(pend_rep[k])
    );
  end

  // Fixed priority: lowest key index wins (loop runs downward, last hit wins).
  logic       win_any, win_rep;
  logic [3:0] win_idx;
  always_comb begin
    win_any = 1'b0;
    win_rep = 1'b0;
    win_idx = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (pend[k]) begin
        win_any = 1'b1;
        win_idx = 4'(k);
        win_rep = pend_rep[k];
      end
    end
    for (int k = 0; k < NUM_KEYS; k++) grant[k] = win_any && (win_idx == 4'(k));
  end

  // Event FIFO: entry = {repeat, key index}
  logic [4:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] count;
  logic          overflow, empty, full, pop, push, clear;
  logic [4:0]    head;

  assign empty = (count == '0);
  assign full  = (count == NW'(FIFO_DEPTH));
  assign head  = mem[rd_ptr];
  assign clear = write && (address == 2'd3);
  assign pop   = read && (address == 2'd1) && !empty;
  // Popping frees a slot this same cycle, so a full FIFO still accepts.
  assign push  = win_any && (!full || pop);

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= {win_rep, win_idx};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
      if (win_any && !push) overflow <= 1'b1;
    end
  end

  logic [31:0] status;
  always_comb begin
    status                 = '0;
    status[NUM_KEYS-1:0]   = deb_level;
    status[15]             = empty;
    status[20:16]          = 5'(count);
    status[31]             = overflow;
  end

  logic unused_wdata;
  assign unused_wdata = ^writedata[31:2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
      ctrl     <= '0;
    end else begin
      if (read) begin
        case (address)
          2'd0:    readdata <= status;
          2'd1:    readdata <= empty ? 32'd0 : {1'b1, 22'd0, head[4], 4'd0, head[3:0]};
          2'd2:    readdata <= {30'd0, ctrl};
          default: readdata <= '0;
        endcase
      end
      if (write && address == 2'd2) ctrl <= writedata[1:0];
      irq <= ctrl[0] & ~empty;
    end
  end
endmodule
